// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment capture path: active-low gfedcba
// segment codes, anode position selects, capture FSM states and BCD helpers.
package sevseg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] AN_MS_TENS   = 4'b1110;
  localparam logic [3:0] AN_MS_HUND   = 4'b1101;
  localparam logic [3:0] AN_SEC_UNITS = 4'b1011;
  localparam logic [3:0] AN_SEC_TENS  = 4'b0111;
  localparam logic [3:0] AN_NONE      = 4'b1111;

  typedef enum logic [1:0] {
    WAIT,
    SETTLE,
    CAPTURED
  } cap_state_e;

  // A scan slot is legal only when exactly one anode is driven low.
  function automatic logic an_valid(input logic [3:0] an);
    return $countones(~an) == 1;
  endfunction

  function automatic logic [1:0] an_pos(input logic [3:0] an);
    case (an)
      AN_MS_HUND:   return 2'd1;
      AN_SEC_UNITS: return 2'd2;
      AN_SEC_TENS:  return 2'd3;
      default:      return 2'd0;
    endcase
  endfunction

  function automatic logic [5:0] bcd_seconds(input logic [3:0] tens, input logic [3:0] units);
    return 6'(tens) * 6'd10 + 6'(units);
  endfunction

  function automatic logic [9:0] bcd_millis(input logic [3:0] hund, input logic [3:0] tens);
    return 10'(hund) * 10'd100 + 10'(tens) * 10'd10;
  endfunction

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Combinational active-low segment pattern to BCD decoder; any pattern that
// is not a digit 0..9 (blank included) reports valid_o=0 with bcd_o=0.
module seven_seg_pattern_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       valid_o,
  output logic [3:0] bcd_o
);

  always_comb begin
    // NOTE: both outputs get a default before the case so no latch is inferred.
    valid_o = 1'b1;
    bcd_o   = 4'd0;
    case (seg_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Captures a multiplexed 4-digit seven-segment display and rebuilds seconds and
// milliseconds. Define SEVEN_SEG_CAPTURE_SYNC_EN to add a two-flop input synchronizer.
module seven_seg_capture
  import sevseg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] digits,
  output logic [5:0]  seconds,
  output logic [9:0]  milliseconds,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam logic [3:0] CNT_TARGET = 4'(SETTLE_CYCLES);

  logic [3:0] an_in;
  logic [6:0] seg_in;

`ifdef SEVEN_SEG_CAPTURE_SYNC_EN
  logic [3:0] an_s1_q, an_s2_q;
  logic [6:0] seg_s1_q, seg_s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_s1_q  <= AN_NONE;
      an_s2_q  <= AN_NONE;
      seg_s1_q <= SEG_BLANK;
      seg_s2_q <= SEG_BLANK;
    end else begin
      an_s1_q  <= an;
      an_s2_q  <= an_s1_q;
      seg_s1_q <= seg;
      seg_s2_q <= seg_s1_q;
    end
  end

  assign an_in  = an_s2_q;
  assign seg_in = seg_s2_q;
`else
  assign an_in  = an;
  assign seg_in = seg;
`endif

  cap_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  an_h_q, an_h_d;
  logic [6:0]  seg_h_q, seg_h_d;
  logic [3:0]  seen_q, seen_d;
  logic        err_acc_q, err_acc_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] digits_q, digits_d;
  logic [5:0]  seconds_q, seconds_d;
  logic [9:0]  millis_q, millis_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        capture;
  logic        changed;
  logic        dec_valid;
  logic [3:0]  dec_bcd;
  logic [1:0]  pos;

  // The held sample equals the live input whenever a capture fires.
  seven_seg_pattern_decode u_decode (
    .seg_i   (seg_h_q),
    .valid_o (dec_valid),
    .bcd_o   (dec_bcd)
  );

  assign changed = {an_in, seg_in} != {an_h_q, seg_h_q};
  assign pos     = an_pos(an_h_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    an_h_d  = an_h_q;
    seg_h_d = seg_h_q;
    capture = 1'b0;
    unique case (state_q)
      WAIT: begin
        if (an_valid(an_in)) begin
          state_d = SETTLE;
          cnt_d   = 4'd1;
          an_h_d  = an_in;
          seg_h_d = seg_in;
        end
      end
      SETTLE: begin
        if (changed) begin
          an_h_d  = an_in;
          seg_h_d = seg_in;
          cnt_d   = 4'd1;
          if (!an_valid(an_in)) state_d = WAIT;
        end else if (cnt_q == CNT_TARGET) begin
          capture = 1'b1;
          state_d = CAPTURED;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CAPTURED: begin
        if (changed) begin
          an_h_d  = an_in;
          seg_h_d = seg_in;
          cnt_d   = 4'd1;
          state_d = an_valid(an_in) ? SETTLE : WAIT;
        end
      end
      default: state_d = WAIT;
    endcase
  end

  always_comb begin
    seen_d    = seen_q;
    err_acc_d = err_acc_q;
    shadow_d  = shadow_q;
    digits_d  = digits_q;
    seconds_d = seconds_q;
    millis_d  = millis_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (capture) begin
      shadow_d[{pos, 2'b00} +: 4] = dec_valid ? dec_bcd : 4'd0;
      seen_d[pos]                 = 1'b1;
      err_acc_d                   = err_acc_q | ~dec_valid;
      if (seen_d == 4'hF) begin
        if (err_acc_d || shadow_d[15:12] > 4'd5) begin
          err_d = 1'b1;
        end else begin
          digits_d  = shadow_d;
          seconds_d = bcd_seconds(shadow_d[15:12], shadow_d[11:8]);
          millis_d  = bcd_millis(shadow_d[7:4], shadow_d[3:0]);
          valid_d   = 1'b1;
        end
        seen_d    = 4'h0;
        err_acc_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= WAIT;
      cnt_q     <= 4'd0;
      an_h_q    <= AN_NONE;
      seg_h_q   <= SEG_BLANK;
      seen_q    <= 4'h0;
      err_acc_q <= 1'b0;
      shadow_q  <= 16'h0;
      digits_q  <= 16'h0;
      seconds_q <= 6'd0;
      millis_q  <= 10'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      an_h_q    <= an_h_d;
      seg_h_q   <= seg_h_d;
      seen_q    <= seen_d;
      err_acc_q <= err_acc_d;
      shadow_q  <= shadow_d;
      digits_q  <= digits_d;
      seconds_q <= seconds_d;
      millis_q  <= millis_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign digits       = digits_q;
  assign seconds      = seconds_q;
  assign milliseconds = millis_q;
  assign frame_valid  = valid_q;
  assign frame_err    = err_q;

endmodule
